// File: rtl/enc12_pkg.sv
// Shared constants and helpers for the (12,7) systematic parity encoder.
// Bit k of each mask selects data bit b[k] into that parity bit.
package enc12_pkg;

    localparam int DATA_W = 7;
    localparam int CW_W   = 12;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CW_W-1:0]   code_t;

    localparam data_t P7  = 7'h63;
    localparam data_t P8  = 7'h35;
    localparam data_t P9  = 7'h6B;
    localparam data_t P10 = 7'h6B;
    localparam data_t P11 = 7'h6A;

    function automatic code_t parity_encode(input data_t b);
        return {^(b & P11), ^(b & P10), ^(b & P9), ^(b & P8), ^(b & P7), b};
    endfunction

endpackage

// File: rtl/enc12_7_core.sv
// Purely combinational (12,7) systematic encoder: data in the low 7 bits,
// five mask-selected parity bits above.
module enc12_7_core
    import enc12_pkg::*;
(
    input  data_t data_i,
    output code_t code_o
);

    assign code_o = parity_encode(data_i);

endmodule

// File: rtl/encoder_share_ctrl.sv
// Round-robin shares one (12,7) encoder between NUM_REQ requesters; results
// land in a 2-entry FIFO (one cycle to out_valid) with a wrapping accept count.
module encoder_share_ctrl
    import enc12_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW_W-1:0]           out_code,
    output logic [SRC_W-1:0]          out_src,
    output logic [CNT_W-1:0]          enc_count
);

    typedef struct packed {
        code_t            code;
        logic [SRC_W-1:0] src;
    } entry_t;

    entry_t             buf_q [2];
    entry_t             buf_d [2];
    logic [1:0]         cnt_q, cnt_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   enc_cnt_q, enc_cnt_d;

    logic               grant_vld;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W:0]     scan;
    data_t              grant_data;
    code_t              grant_code;
    logic               space;
    logic               accept;
    logic               pop;
    entry_t             new_entry;

    assign out_valid = (cnt_q != 2'd0);
    assign out_code  = buf_q[0].code;
    assign out_src   = buf_q[0].src;
    assign enc_count = enc_cnt_q;

    assign pop    = out_valid && out_ready;
    assign space  = (cnt_q < 2'd2) || pop;
    assign accept = space && grant_vld;

    // Scan index is one bit wider so the modulo wrap works for any NUM_REQ.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        scan       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (scan >= (SRC_W+1)'(NUM_REQ))
                scan = scan - (SRC_W+1)'(NUM_REQ);
            if (!grant_vld && req_valid[scan[SRC_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && grant_idx == SRC_W'(i)) begin
                grant_data   = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = space;
            end
        end
    end

    enc12_7_core u_enc (
        .data_i (grant_data),
        .code_o (grant_code)
    );

    assign new_entry = '{code: grant_code, src: grant_idx};

    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        enc_cnt_d = enc_cnt_q;
        case ({accept, pop})
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = new_entry;
                end else begin
                    buf_d[0] = new_entry;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2)
                    buf_d[0] = buf_q[1];
                cnt_d = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0)
                    buf_d[0] = new_entry;
                else
                    buf_d[1] = new_entry;
                cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase
        if (accept) begin
            ptr_d     = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
            enc_cnt_d = enc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            enc_cnt_q <= '0;
        end else begin
            buf_q[0]  <= buf_d[0];
            buf_q[1]  <= buf_d[1];
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            enc_cnt_q <= enc_cnt_d;
        end
    end

endmodule

// File: tb/tb_encoder_share_ctrl.sv
// Randomised and directed stimulus for encoder_share_ctrl against a queue-based
// reference model; a separate monitor checks every presented codeword.
module tb_encoder_share_ctrl;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [7*N-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [11:0]      out_code;
    logic [1:0]       out_src;
    logic [15:0]      enc_count;

    typedef struct {
        logic [11:0] code;
        int          src;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          m_ptr    = 0;
    int          m_cnt    = 0;
    int unsigned m_enc    = 0;
    logic [6:0]  dat [N];
    bit          rand_data = 1'b1;

    encoder_share_ctrl #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_src   (out_src),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_code(input logic [6:0] b);
        logic [11:0] c;
        c[6:0] = b;
        c[7]   = b[0] ^ b[1] ^ b[5] ^ b[6];
        c[8]   = b[0] ^ b[2] ^ b[4] ^ b[5];
        c[9]   = b[0] ^ b[1] ^ b[3] ^ b[5] ^ b[6];
        c[10]  = c[9];
        c[11]  = b[1] ^ b[3] ^ b[5] ^ b[6];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the edge, compare at the falling edge,
    // then advance the model by whatever the coming edge should accept.
    task automatic cycle(input logic [N-1:0] v, input logic ordy, input logic r);
        int         g;
        logic       space;
        logic [N-1:0] exp_rdy;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        out_ready = ordy;
        for (int i = 0; i < N; i++)
            req_data[7*i +: 7] = dat[i];
        @(negedge clk);
        if (r) begin
            sbq.delete();
            m_cnt = 0;
            m_ptr = 0;
            m_enc = 0;
            return;
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, (m_cnt > 0)});
        check("enc_count", {16'd0, enc_count}, m_enc & 32'hFFFF);
        space = (m_cnt < 2) || (m_cnt > 0 && ordy);
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N])
                g = (m_ptr + k) % N;
        exp_rdy = '0;
        if (space && g >= 0)
            exp_rdy[g] = 1'b1;
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        if (m_cnt > 0 && ordy)
            m_cnt--;
        if (exp_rdy != '0) begin
            sbq.push_back('{ref_code(dat[g]), g});
            m_cnt++;
            m_ptr = (g + 1) % N;
            m_enc++;
            if (rand_data)
                dat[g] = 7'($urandom);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: code 0x%0h src %0d with nothing expected", out_code, out_src);
                end else begin
                    check("out_code", {20'd0, out_code}, {20'd0, sbq[0].code});
                    check("out_src", {30'd0, out_src}, sbq[0].src);
                    if (out_ready)
                        void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < N; i++)
            dat[i] = 7'($urandom);
        repeat (3) cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0);
        check("rst_code", {20'd0, out_code}, 32'd0);
        check("rst_src", {30'd0, out_src}, 32'd0);

        // Known codewords from requester 0.
        rand_data = 1'b0;
        dat[0] = 7'h01; cycle(4'b0001, 1'b1, 1'b0);
        dat[0] = 7'h02; cycle(4'b0001, 1'b1, 1'b0);
        dat[0] = 7'h7F; cycle(4'b0001, 1'b1, 1'b0);
        dat[0] = 7'h00; cycle(4'b0001, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        check("count_after_4", {16'd0, enc_count}, 32'd4);
        rand_data = 1'b1;

        // Backpressure with requesters 1 and 2, then a single pop-and-push.
        for (int i = 0; i < N; i++)
            dat[i] = 7'($urandom);
        repeat (4) cycle(4'b0110, 1'b0, 1'b0);
        cycle(4'b1110, 1'b1, 1'b0);
        repeat (3) cycle('0, 1'b1, 1'b0);

        repeat (40) cycle(4'b1111, 1'b1, 1'b0);
        repeat (40) cycle(4'b1001, 1'($urandom_range(0, 3) != 0), 1'b0);
        repeat (400) cycle(4'($urandom), 1'($urandom), 1'b0);

        // Reset with the buffer full, then all requesters compete.
        repeat (3) cycle(4'b1111, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1);
        repeat (6) cycle(4'b1111, 1'b1, 1'b0);

        // Counter wrap.
        cycle('0, 1'b1, 1'b1);
        repeat (65537) cycle(4'b0001, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        check("count_wrap", {16'd0, enc_count}, 32'd1);

        repeat (4) cycle('0, 1'b1, 1'b0);
        check("sb_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
